// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the stream_demux_1xn block:
//   slot_state_e : occupancy state of one output slot (SLOT_EMPTY / SLOT_FULL)
//   sel_width(n) : width of a channel index able to address n channels
// ---------------------------------------------------------------------------
package demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // A single-bit select is kept even for n <= 2 so the port never collapses
  // to zero width.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// ---------------------------------------------------------------------------
// demux_out_slot
// One-entry registered output slot of the stream demultiplexer.
// Ports:
//   clk     : rising-edge clock
//   i_rst   : synchronous active-high reset (empties the slot, clears data)
//   i_load  : write i_d into the slot this cycle
//   i_pop   : consumer takes the held word this cycle
//   i_d     : incoming word
//   o_valid : slot holds a word
//   o_q     : held word (keeps its last value while empty)
// ---------------------------------------------------------------------------
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_pop,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);

  slot_state_e  r_state;
  slot_state_e  w_state_nxt;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= SLOT_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // A load always wins over a pop on the same edge, so a popped slot can be
  // refilled without a bubble.
  always_ff @(posedge clk) begin
    if (i_rst)       r_data <= '0;
    else if (i_load) r_data <= i_d;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load)           w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (i_pop && !i_load) w_state_nxt = SLOT_EMPTY;
      default:                          w_state_nxt = SLOT_EMPTY;
    endcase
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_q     = r_data;

endmodule

// File: rtl/stream_demux_1xn.sv
// ---------------------------------------------------------------------------
// stream_demux_1xn
// 1-to-N_CH valid/ready stream demultiplexer with one registered slot per
// output channel, so a stalled consumer never blocks the other channels.
// Optional per-channel saturating transfer counters: STREAM_DEMUX_CNT_EN.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : producer has a word
//   in_ready   : word is accepted this cycle (combinational on in_sel/state)
//   in_data    : word to route
//   in_sel     : destination channel index
//   out_valid  : bit k set while channel k holds a word
//   out_ready  : bit k set when consumer k takes its word
//   out_data   : channel k word at [k*W +: W]
//   drop       : one-cycle pulse after a word with out-of-range in_sel
//   xfer_cnt   : channel k completed-transfer count at [k*CNT_W +: CNT_W]
//                (constant 0 unless STREAM_DEMUX_CNT_EN is defined)
// ---------------------------------------------------------------------------
module stream_demux_1xn
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = sel_width(N_CH),
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  logic [SEL_W-1:0]      in_sel,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [N_CH*W-1:0]     out_data,
  output logic                  drop,
  output logic [N_CH*CNT_W-1:0] xfer_cnt
);

  logic            w_in_range;
  logic            w_in_fire;
  logic [N_CH-1:0] w_load;
  logic [N_CH-1:0] w_pop;
  logic            r_drop;

  // Extra bit so N_CH itself is representable in the comparison.
  assign w_in_range = ({1'b0, in_sel} < (SEL_W+1)'(N_CH));

  // Out-of-range words are always accepted so they drain instead of
  // wedging the producer.
  always_comb begin
    in_ready = 1'b1;
    if (w_in_range) in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  end

  assign w_in_fire = in_valid & in_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_load[k] = w_in_fire & w_in_range & (in_sel == SEL_W'(k));
    assign w_pop[k]  = out_valid[k] & out_ready[k];

    demux_out_slot #(.W(W)) u_slot (
      .clk     (clk),
      .i_rst   (rst),
      .i_load  (w_load[k]),
      .i_pop   (w_pop[k]),
      .i_d     (in_data),
      .o_valid (out_valid[k]),
      .o_q     (out_data[k*W +: W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_drop <= 1'b0;
    else     r_drop <= w_in_fire & ~w_in_range;
  end

  assign drop = r_drop;

`ifdef STREAM_DEMUX_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] r_cnt [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst)           r_cnt[k] <= '0;
      else if (w_pop[k]) r_cnt[k] <= sat_inc(r_cnt[k]);
    end
    assign xfer_cnt[k*CNT_W +: CNT_W] = r_cnt[k];
  end
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
module tb_stream_demux_1xn;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;
  localparam int N3   = 3;
  localparam int CW3  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT: 4 channels
  logic              rst;
  logic              in_valid, in_ready;
  logic [W-1:0]      in_data;
  logic [1:0]        in_sel;
  logic [N-1:0]      out_valid, out_ready;
  logic [N*W-1:0]    out_data;
  logic              drop;
  logic [N*CW-1:0]   xfer_cnt;

  // second DUT: 3 channels (out-of-range selects possible), 2-bit counters
  logic              in_valid3, in_ready3;
  logic [W-1:0]      in_data3;
  logic [1:0]        in_sel3;
  logic [N3-1:0]     out_valid3, out_ready3;
  logic [N3*W-1:0]   out_data3;
  logic              drop3;
  logic [N3*CW3-1:0] xfer_cnt3;

  stream_demux_1xn #(.W(W), .N_CH(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop(drop), .xfer_cnt(xfer_cnt)
  );

  stream_demux_1xn #(.W(W), .N_CH(N3), .CNT_W(CW3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .drop(drop3), .xfer_cnt(xfer_cnt3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the 4-channel DUT: each channel holds at most one
  // word; a held word leaves when its consumer is ready, and a new word may
  // enter a channel that is empty or being emptied this cycle.
  bit         m_full [N];
  logic [W-1:0] m_word [N];
  int         m_cnt  [N];

  function automatic bit model_ready(input logic [1:0] s, input logic [N-1:0] r);
    return (int'(s) >= N) || !m_full[s] || r[s];
  endfunction

  function automatic logic [N-1:0] exp_vld();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int k);
`ifdef STREAM_DEMUX_CNT_EN
    return CW'(m_cnt[k]);
`else
    return (k < 0) ? CW'(1) : '0;
`endif
  endfunction

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic step();
    logic         r    = rst;
    logic         v    = in_valid;
    logic [1:0]   s    = in_sel;
    logic [W-1:0] d    = in_data;
    logic [N-1:0] ordy = out_ready;
    bit           rdy  = model_ready(s, ordy);
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < N; k++) begin
        m_full[k] = 0; m_word[k] = '0; m_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (m_full[k] && ordy[k]) begin
          m_full[k] = 0;
          if (m_cnt[k] < CMAX) m_cnt[k]++;
        end
      if (v && rdy) begin
        m_full[s] = 1; m_word[s] = d;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_sel = 2'd1; in_data = 8'h3C; out_ready = '0;
    in_valid3 = 1; in_sel3 = 2'd0; in_data3 = 8'h3C; out_ready3 = '0;
    step(); step();
    n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0000", out_valid); end
    n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop got %b exp 0", drop); end
    n_cmp++; if (xfer_cnt !== '0) begin n_bad++; $display("FAIL reset_xfer_cnt got %h exp 0", xfer_cnt); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    n_cmp++; if (out_valid3 !== '0) begin n_bad++; $display("FAIL reset_out_valid3 got %b exp 000", out_valid3); end
    rst = 0; in_valid = 0; in_valid3 = 0;
    step();
    n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL reset_idle_valid got %b exp 0000", out_valid); end
  endtask

  task automatic test_basic_routing();
    out_ready = 4'b1111;
    for (int i = 0; i < N; i++) begin
      in_valid = 1; in_sel = 2'(i); in_data = 8'(8'hA0 + i);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL route_in_ready ch%0d got %b exp 1", i, in_ready); end
      step();
      n_cmp++; if (out_valid !== 4'(1 << i)) begin n_bad++; $display("FAIL route_valid ch%0d got %b exp %b", i, out_valid, 4'(1 << i)); end
      n_cmp++; if (out_data[i*W +: W] !== 8'(8'hA0 + i)) begin n_bad++; $display("FAIL route_data ch%0d got %h exp %h", i, out_data[i*W +: W], 8'(8'hA0 + i)); end
    end
    in_valid = 0;
    step();
    n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL route_drain got %b exp 0000", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 4'b1011;
    in_valid = 1; in_sel = 2'd2; in_data = 8'h55;
    step();
    n_cmp++; if (out_valid[2] !== 1'b1 || out_data[2*W +: W] !== 8'h55) begin n_bad++; $display("FAIL stall_load got v=%b d=%h exp v=1 d=55", out_valid[2], out_data[2*W +: W]); end
    in_data = 8'h66;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
    step();
    n_cmp++; if (out_data[2*W +: W] !== 8'h55 || out_valid[2] !== 1'b1) begin n_bad++; $display("FAIL stall_hold got v=%b d=%h exp v=1 d=55", out_valid[2], out_data[2*W +: W]); end
    in_sel = 2'd1; in_data = 8'h77;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL indep_in_ready got %b exp 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 4'b0110 || out_data[1*W +: W] !== 8'h77) begin n_bad++; $display("FAIL indep_deliver got v=%b d=%h exp v=0110 d=77", out_valid, out_data[1*W +: W]); end
    n_cmp++; if (out_data[2*W +: W] !== 8'h55) begin n_bad++; $display("FAIL indep_ch2_hold got %h exp 55", out_data[2*W +: W]); end
    in_sel = 2'd2; in_data = 8'h66; out_ready = 4'b1111;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 4'b0100 || out_data[2*W +: W] !== 8'h66) begin n_bad++; $display("FAIL release_load got v=%b d=%h exp v=0100 d=66", out_valid, out_data[2*W +: W]); end
    in_valid = 0;
    step();
    n_cmp++; if (out_valid !== '0) begin n_bad++; $display("FAIL release_drain got %b exp 0000", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    int c0;
    c0 = m_cnt[0];
    out_ready = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      w = 8'($urandom);
      in_valid = 1; in_sel = 2'd0; in_data = w;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready word%0d got %b exp 1", i, in_ready); end
      step();
      n_cmp++; if (out_valid[0] !== 1'b1 || out_data[W-1:0] !== w) begin n_bad++; $display("FAIL b2b_word%0d got v=%b d=%h exp v=1 d=%h", i, out_valid[0], out_data[W-1:0], w); end
    end
    in_valid = 0;
    step();
    n_cmp++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b exp 0", out_valid[0]); end
    n_cmp++; if (m_cnt[0] - c0 != 8 || xfer_cnt[CW-1:0] !== exp_cnt(0)) begin n_bad++; $display("FAIL b2b_count got %0d exp %0d", xfer_cnt[CW-1:0], exp_cnt(0)); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = 1'($urandom);
      in_sel    = 2'($urandom);
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      #1;
      n_cmp++; if (in_ready !== model_ready(in_sel, out_ready)) begin n_bad++; $display("FAIL rand_in_ready cyc%0d got %b exp %b", c, in_ready, model_ready(in_sel, out_ready)); end
      step();
      n_cmp++; if (out_valid !== exp_vld()) begin n_bad++; $display("FAIL rand_out_valid cyc%0d got %b exp %b", c, out_valid, exp_vld()); end
      for (int k = 0; k < N; k++) begin
        if (m_full[k]) begin
          n_cmp++; if (out_data[k*W +: W] !== m_word[k]) begin n_bad++; $display("FAIL rand_data cyc%0d ch%0d got %h exp %h", c, k, out_data[k*W +: W], m_word[k]); end
        end
        n_cmp++; if (xfer_cnt[k*CW +: CW] !== exp_cnt(k)) begin n_bad++; $display("FAIL rand_cnt cyc%0d ch%0d got %0d exp %0d", c, k, xfer_cnt[k*CW +: CW], exp_cnt(k)); end
      end
      n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL rand_drop cyc%0d got %b exp 0", c, drop); end
    end
    rst = 0; in_valid = 0;
    step();
  endtask

  task automatic test_out_of_range();
    out_ready3 = 3'b000;
    in_valid3 = 1; in_sel3 = 2'd2; in_data3 = 8'h42;
    step();
    in_valid3 = 0;
    n_cmp++; if (out_valid3 !== 3'b100) begin n_bad++; $display("FAIL oor_preload got %b exp 100", out_valid3); end
    in_valid3 = 1; in_sel3 = 2'd3; in_data3 = 8'hFF;
    #1;
    n_cmp++; if (in_ready3 !== 1'b1) begin n_bad++; $display("FAIL oor_in_ready got %b exp 1", in_ready3); end
    n_cmp++; if (drop3 !== 1'b0) begin n_bad++; $display("FAIL oor_drop_before got %b exp 0", drop3); end
    step();
    in_valid3 = 0;
    n_cmp++; if (drop3 !== 1'b1) begin n_bad++; $display("FAIL oor_drop_pulse got %b exp 1", drop3); end
    n_cmp++; if (out_valid3 !== 3'b100 || out_data3[2*W +: W] !== 8'h42) begin n_bad++; $display("FAIL oor_no_change got v=%b d=%h exp v=100 d=42", out_valid3, out_data3[2*W +: W]); end
    step();
    n_cmp++; if (drop3 !== 1'b0) begin n_bad++; $display("FAIL oor_drop_end got %b exp 0", drop3); end
    out_ready3 = 3'b111;
    step();
    n_cmp++; if (out_valid3 !== 3'b000) begin n_bad++; $display("FAIL oor_drain got %b exp 000", out_valid3); end
    out_ready3 = 3'b000;
  endtask

  task automatic test_counter();
    logic [CW3-1:0] exp_sat;
`ifdef STREAM_DEMUX_CNT_EN
    exp_sat = 2'd3;
`else
    exp_sat = 2'd0;
`endif
    rst = 1; step(); rst = 0;
    out_ready3 = 3'b010; in_valid3 = 1; in_sel3 = 2'd1;
    for (int i = 0; i < 5; i++) begin
      in_data3 = 8'(8'h10 + i);
      step();
    end
    in_valid3 = 0;
    step();
    n_cmp++; if (xfer_cnt3[1*CW3 +: CW3] !== exp_sat) begin n_bad++; $display("FAIL cnt_saturate got %0d exp %0d", xfer_cnt3[1*CW3 +: CW3], exp_sat); end
    n_cmp++; if (xfer_cnt3[0 +: CW3] !== 2'd0 || xfer_cnt3[2*CW3 +: CW3] !== 2'd0) begin n_bad++; $display("FAIL cnt_other_ch got %h exp 0 on ch0/ch2", xfer_cnt3); end
    in_valid3 = 1; in_data3 = 8'h99;
    step(); step();
    rst = 1; step(); rst = 0; in_valid3 = 0;
    n_cmp++; if (xfer_cnt3 !== '0) begin n_bad++; $display("FAIL cnt_reset got %h exp 0", xfer_cnt3); end
    n_cmp++; if (out_valid3 !== '0) begin n_bad++; $display("FAIL cnt_reset_valid got %b exp 000", out_valid3); end
    out_ready3 = '0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_sel = '0; in_data = '0; out_ready = '0;
    in_valid3 = 0; in_sel3 = '0; in_data3 = '0; out_ready3 = '0;
    for (int k = 0; k < N; k++) begin m_full[k] = 0; m_word[k] = '0; m_cnt[k] = 0; end
    test_reset();
    test_basic_routing();
    test_stall();
    test_back_to_back();
    test_random();
    test_out_of_range();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_demux_1xn.md
Name: stream_demux_1xn

Overview:
- Parametrised 1-to-N stream demultiplexer. Successor to the gate-level 1x2/1x4 demux cells.
- Routes a W-bit data word to one of N_CH output channels selected by in_sel, using a valid/ready handshake.
- Each channel has a one-entry registered output slot, so a stalled channel never blocks the others.
- Sits between a single producer (e.g. a packet or command source) and N independent consumers.

Parameters:
- W, 8, data width in bits (>=1)
- N_CH, 4, number of output channels (>=2)
- SEL_W, $clog2(N_CH), select width (derived; do not override)
- CNT_W, 16, width of each per-channel transfer counter (used only with the optional feature)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  W  word to route
- in_sel  input  SEL_W  destination channel index
- out_valid  output  N_CH  bit k: channel k slot holds a word
- out_ready  input  N_CH  bit k: consumer k takes the word
- out_data  output  N_CH*W  channel k occupies bits [k*W +: W]
- drop  output  1  one-cycle pulse: a word with out-of-range in_sel was discarded
- xfer_cnt  output  N_CH*CNT_W  per-channel completed-transfer counts, channel k at [k*CNT_W +: CNT_W]

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge): out_valid=0, out_data=0, drop=0, xfer_cnt=0. Any word held in a slot is discarded; no handshake completes in that cycle.
- Input accept: in_fire = in_valid & in_ready.
- in_ready is combinational: 1 if in_sel >= N_CH; otherwise ~out_valid[in_sel] | out_ready[in_sel]. It depends only on in_sel and state, never on in_valid.
- Latency: a word accepted at edge t shows out_valid[in_sel]=1 and its data after edge t, i.e. available to the consumer in cycle t+1. Throughput is 1 word/cycle per channel when the consumer keeps ready high.
- Output fire: out_fire[k] = out_valid[k] & out_ready[k]. On an edge with out_fire[k] and no new load into slot k, out_valid[k] clears.
- Simultaneous pop and load on the same channel: slot k takes the new word and out_valid[k] stays 1.
- Stall: while out_valid[k] & ~out_ready[k], out_data slice k holds stable and in_ready stays low for words targeting k.
- Words targeting other channels continue unaffected.
- Empty slot: out_data slice k keeps its last value. Consumers must not rely on it.
- Out-of-range select (in_sel >= N_CH, possible only when N_CH is not a power of 2): the word is accepted and discarded, and drop=1 for exactly the following cycle. drop is 0 otherwise.
- Per-slot state machine, 2 states:
  - EMPTY -> FULL on load.
  - FULL -> FULL on load with pop, or on stall.
  - FULL -> EMPTY on pop without load.
- No arithmetic on data; data passes bit-exact.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- With the macro defined: xfer_cnt[k] increments by 1 on each out_fire[k] and saturates at all-ones (no wrap). It is cleared by rst.
- Without the macro: xfer_cnt is driven constant 0, no counter registers are built, and the port list is unchanged.

Decomposition:
- Shared package demux_pkg: the slot state enum (SLOT_EMPTY, SLOT_FULL) and a function sel_width(n) returning the select width for n channels.
- Sub-module demux_out_slot: one-entry register slice with load, pop, valid and data. Instantiated N_CH times in a generate loop.
- The top level holds the select decode, in_ready mux, drop flag and the optional counters.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0000, drop=0, xfer_cnt all 0, no slot loaded.
- Basic routing: send words 0xA0..0xA3 to sel=0..3 with out_ready=1111 -> each appears on its own channel exactly 1 cycle later; in_ready stays 1 throughout.
- Stall and independence: out_ready[2]=0, send 0x55 then 0x66 to sel=2, then 0x77 to sel=1:
  - 0x55 is held on channel 2 and in_ready=0 while 0x66 is presented.
  - After switching to sel=1, 0x77 is accepted and delivered on channel 1.
  - Raising out_ready[2] releases 0x55, then 0x66 loads.
- Back-to-back on one channel: out_ready[0]=1, stream 8 words to sel=0 -> 8 consecutive out_fire[0] with no bubble, and the pop-with-load path is exercised.
- Out-of-range select: N_CH=3, send in_sel=3 with data 0xFF -> in_ready=1, drop=1 for one cycle, no out_valid change.
- Counter (with STREAM_DEMUX_CNT_EN, CNT_W=2): 5 transfers on channel 1 -> xfer_cnt[1]=3 (saturated); rst asserted mid-stream -> all counts return to 0.
